// File: rtl/io_ports_pkg.sv
// Shared register offsets, status/irq bit positions and count helper for io_ports.
// No logic of its own; imported by io_ports and io_kbd_fifo.
// Build option IO_KBD_FIFO_EN selects the keyboard buffer flavour (see io_kbd_fifo).
package io_ports_pkg;

    localparam logic [2:0] IO_OFS_KBD    = 3'd0;
    localparam logic [2:0] IO_OFS_TIMER  = 3'd1;
    localparam logic [2:0] IO_OFS_STATUS = 3'd2;
    localparam logic [2:0] IO_OFS_POP    = 3'd3;
    localparam logic [2:0] IO_OFS_CTRL   = 3'd4;

    localparam int ST_NONEMPTY = 0;
    localparam int ST_OVF      = 1;
    localparam int ST_TICK     = 2;

    localparam int IRQ_KEY  = 0;
    localparam int IRQ_TICK = 1;

    localparam int CTRL_RUN = 0;
    localparam int CTRL_CLR = 1;

    // Wide enough for a 16-deep FIFO holding 16 entries.
    localparam int IO_CNT_W = 5;

    function automatic logic [3:0] sat_count(input logic [IO_CNT_W-1:0] c);
        return (c > IO_CNT_W'(15)) ? 4'd15 : c[3:0];
    endfunction

endpackage

// File: rtl/io_kbd_fifo.sv
// Keyboard receive buffer: DEPTH-entry drop-on-full FIFO with IO_KBD_FIFO_EN, else a one-byte latch.
// Latency: pushed byte visible on head the cycle after the push edge; head/count/full/empty are registered state.
// Backpressure: none; full FIFO drops the byte unless a pop lands on the same edge, latch overwrites.
module io_kbd_fifo
    import io_ports_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic [7:0]          din,
    input  logic                pop,
    output logic [7:0]          head,
    output logic [IO_CNT_W-1:0] count,
    output logic                full,
    output logic                empty
);

`ifdef IO_KBD_FIFO_EN
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]          mem [DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [IO_CNT_W-1:0] cnt;
    logic                do_pop;
    logic                do_push;

    assign full    = (cnt == IO_CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? 8'h00 : mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end
`else
    logic [7:0] byte_q;
    logic       vld;
    logic       unused_depth;

    assign unused_depth = ^DEPTH;
    assign full  = vld;
    assign empty = ~vld;
    assign head  = vld ? byte_q : 8'h00;
    assign count = IO_CNT_W'(vld);

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_q <= 8'h00;
            vld    <= 1'b0;
        end else if (push) begin
            byte_q <= din;
            vld    <= 1'b1;
        end else if (pop) begin
            vld    <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/io_ports.sv
// AVR port-mapped I/O block: 8-address window with video regs, keyboard buffer, tick timer, irq.
// Latency: reads combinational from a; writes, pops and key pushes take effect at the strobe edge.
// Backpressure: none; keyboard overflow flagged sticky. Build option IO_KBD_FIFO_EN picks FIFO vs latch.
module io_ports
    import io_ports_pkg::*;
#(
    parameter logic [15:0] BASE      = 16'h0020,
    parameter int          CLK_HZ    = 25_000_000,
    parameter int          TICK_HZ   = 100,
    parameter int          KBD_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [7:0]  o,
    input  logic        r,
    input  logic        w,
    output logic [7:0]  p,
    input  logic        p_kdone,
    input  logic [7:0]  p_ascii,
    output logic [2:0]  p_border,
    output logic        p_vpage,
    output logic        irq
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic                in_win;
    logic [2:0]          ofs;
    logic                wr_border, wr_vpage, wr_status, wr_irqen, wr_ctrl, rd_pop;
    logic                run, ovf, pend, en_key, en_tick;
    logic [PS_W-1:0]     presc;
    logic [7:0]          tcnt;
    logic                tick, tick_clr, ovf_evt;
    logic [7:0]          kbd_head;
    logic [IO_CNT_W-1:0] kbd_count;
    logic                kbd_full, kbd_empty;
    logic [7:0]          status;
    logic                unused_o;

    assign unused_o  = ^o[7:3];
    assign in_win    = (a[15:3] == BASE[15:3]);
    assign ofs       = a[2:0];
    assign wr_border = w & in_win & (ofs == IO_OFS_KBD);
    assign wr_vpage  = w & in_win & (ofs == IO_OFS_TIMER);
    assign wr_status = w & in_win & (ofs == IO_OFS_STATUS);
    assign wr_irqen  = w & in_win & (ofs == IO_OFS_POP);
    assign wr_ctrl   = w & in_win & (ofs == IO_OFS_CTRL);
    assign rd_pop    = r & in_win & (ofs == IO_OFS_POP);

    io_kbd_fifo #(.DEPTH(KBD_DEPTH)) u_kbd (
        .clock (clock),
        .reset (reset),
        .push  (p_kdone),
        .din   (p_ascii),
        .pop   (rd_pop),
        .head  (kbd_head),
        .count (kbd_count),
        .full  (kbd_full),
        .empty (kbd_empty)
    );

    // A key arriving while full is an overflow unless the same edge pops a byte.
    assign ovf_evt  = p_kdone & kbd_full & ~rd_pop;
    assign tick_clr = wr_ctrl & o[CTRL_CLR];
    assign tick     = run & ~tick_clr & (presc == PS_W'(DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            p_border <= 3'd0;
            p_vpage  <= 1'b0;
            en_key   <= 1'b0;
            en_tick  <= 1'b0;
            run      <= 1'b1;
            presc    <= '0;
            tcnt     <= 8'd0;
            ovf      <= 1'b0;
            pend     <= 1'b0;
        end else begin
            if (wr_border)
                p_border <= o[2:0];
            if (wr_vpage)
                p_vpage <= o[0];
            if (wr_irqen) begin
                en_key  <= o[IRQ_KEY];
                en_tick <= o[IRQ_TICK];
            end
            if (wr_ctrl)
                run <= o[CTRL_RUN];
            if (tick_clr) begin
                presc <= '0;
                tcnt  <= 8'd0;
            end else if (run) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick)
                    tcnt <= tcnt + 1'b1;
            end
            // Hardware set beats a software clear on the same edge.
            if (ovf_evt)
                ovf <= 1'b1;
            else if (wr_status && o[ST_OVF])
                ovf <= 1'b0;
            if (tick)
                pend <= 1'b1;
            else if (wr_status && o[ST_TICK])
                pend <= 1'b0;
        end
    end

    assign irq = (en_key & ~kbd_empty) | (en_tick & pend);

    always_comb begin
        status              = 8'h00;
        status[ST_NONEMPTY] = ~kbd_empty;
        status[ST_OVF]      = ovf;
        status[ST_TICK]     = pend;
        status[7:4]         = sat_count(kbd_count);
    end

    always_comb begin
        p = 8'h00;
        if (in_win) begin
            case (ofs)
                IO_OFS_KBD, IO_OFS_POP: p = kbd_head;
                IO_OFS_TIMER:           p = tcnt;
                IO_OFS_STATUS:          p = status;
                IO_OFS_CTRL:            p = {7'b0, run};
                default:                p = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_io_ports.sv
// Bench for io_ports (CLK_HZ=1000, TICK_HZ=100): directed register-map scenarios plus random traffic,
// every cycle compared against a queue/elapsed-time reference model. Works with or without IO_KBD_FIFO_EN.
module tb_io_ports;

    localparam logic [15:0] BASE = 16'h0020;
    localparam int DIV = 10;
`ifdef IO_KBD_FIFO_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a = '0;
    logic [7:0]  o = '0;
    logic        r = 1'b0;
    logic        w = 1'b0;
    logic [7:0]  p;
    logic        p_kdone = 1'b0;
    logic [7:0]  p_ascii = '0;
    logic [2:0]  p_border;
    logic        p_vpage;
    logic        irq;

    io_ports #(.BASE(BASE), .CLK_HZ(1000), .TICK_HZ(100), .KBD_DEPTH(8)) dut (
        .clock(clock), .reset(reset), .a(a), .o(o), .r(r), .w(w), .p(p),
        .p_kdone(p_kdone), .p_ascii(p_ascii), .p_border(p_border), .p_vpage(p_vpage), .irq(irq)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ovf, m_pend, m_ek, m_et, m_run, m_vpage;
    logic [2:0] m_border;
    int         m_el;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_inwin(input logic [15:0] aa);
        return (int'(aa) >= int'(BASE)) && (int'(aa) <= int'(BASE) + 7);
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] aa);
        int n, off;
        logic [3:0] c;
        if (!m_inwin(aa)) return 8'h00;
        off = int'(aa) - int'(BASE);
        n = q.size();
        c = (n > 15) ? 4'd15 : 4'(n);
        case (off)
            0, 3:    return (n > 0) ? q[0] : 8'h00;
            1:       return 8'((m_el / DIV) % 256);
            2:       return {c, 1'b0, m_pend, m_ovf, n != 0};
            4:       return {7'b0, m_run};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic m_irq();
        return (m_ek && q.size() > 0) || (m_et && m_pend);
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ovf = 0; m_pend = 0; m_ek = 0; m_et = 0; m_run = 1; m_vpage = 0;
        m_border = 3'd0; m_el = 0;
    endfunction

    function automatic void m_step(input logic [15:0] aa, input logic [7:0] od,
                                   input logic rr, input logic ww, input logic kd, input logic [7:0] kb);
        bit inw, tick, ovf_set;
        int off;
        inw = m_inwin(aa);
        off = int'(aa) - int'(BASE);
        tick = 0;
        ovf_set = 0;
        if (inw && ww && off == 4 && od[1]) m_el = 0;
        else if (m_run) begin
            m_el++;
            tick = (m_el % DIV) == 0;
        end
        if (inw && rr && off == 3 && q.size() > 0) void'(q.pop_front());
        if (kd) begin
            if (q.size() < CAP) q.push_back(kb);
            else begin
                ovf_set = 1;
`ifndef IO_KBD_FIFO_EN
                q[0] = kb;
`endif
            end
        end
        if (tick) m_pend = 1;
        else if (inw && ww && off == 2 && od[2]) m_pend = 0;
        if (ovf_set) m_ovf = 1;
        else if (inw && ww && off == 2 && od[1]) m_ovf = 0;
        if (inw && ww) begin
            case (off)
                0: m_border = od[2:0];
                1: m_vpage  = od[0];
                3: begin m_ek = od[0]; m_et = od[1]; end
                4: m_run    = od[0];
                default: ;
            endcase
        end
    endfunction

    task automatic step(input logic [15:0] aa, input logic [7:0] od, input logic rr, input logic ww,
                        input logic kd, input logic [7:0] kb, output logic [7:0] rdat);
        @(negedge clock);
        a = aa; o = od; r = rr; w = ww; p_kdone = kd; p_ascii = kb;
        #2;
        rdat = p;
        chk("p", p, m_read(aa));
        chk("irq", irq, m_irq());
        chk("border", p_border, m_border);
        chk("vpage", p_vpage, m_vpage);
        @(posedge clock);
        m_step(aa, od, rr, ww, kd, kb);
    endtask

    function automatic logic [15:0] adr(input int off);
        return 16'(int'(BASE) + off);
    endfunction

    task automatic wr(input int off, input logic [7:0] d);
        logic [7:0] x;
        step(adr(off), d, 1'b0, 1'b1, 1'b0, 8'h00, x);
    endtask

    task automatic rd(input int off, output logic [7:0] v);
        step(adr(off), 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, v);
    endtask

    task automatic key(input logic [7:0] b);
        logic [7:0] x;
        step(16'hFFFF, 8'h00, 1'b0, 1'b0, 1'b1, b, x);
    endtask

    task automatic idle(input int n);
        logic [7:0] x;
        for (int i = 0; i < n; i++) step(16'hFFFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, x);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1; a = BASE; o = 8'hFF; w = 1; r = 0; p_kdone = 1; p_ascii = 8'h77;
        @(posedge clock);
        @(negedge clock);
        w = 0; p_kdone = 0;
        @(posedge clock);
        #1;
        reset = 0;
        m_reset();
    endtask

    task automatic wait_pre_tick();
        while ((m_el + 1) % DIV != 0) idle(1);
    endtask

    initial begin
        logic [7:0] v;
        logic [15:0] aa;
        int sel;

        do_reset();
        chk("rst_border", p_border, 3'd0);
        chk("rst_irq", irq, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            chk("rst_rd", v, (i == 4) ? 8'h01 : 8'h00);
        end
        wr(0, 8'hFF);
        #1 chk("border_ff", p_border, 3'b111);
        wr(1, 8'h01);
        #1 chk("vpage_1", p_vpage, 1'b1);

        // Keyboard with timer stopped so status is deterministic
        wr(4, 8'h00);
        wr(2, 8'h06);
        wr(3, 8'h01);
`ifdef IO_KBD_FIFO_EN
        key(8'h41);
        #1 chk("irq_key", irq, 1'b1);
        key(8'h42);
        key(8'h43);
        rd(2, v); chk("stat_3", v, 8'h31);
        rd(3, v); chk("pop1", v, 8'h41);
        rd(3, v); chk("pop2", v, 8'h42);
        rd(3, v); chk("pop3", v, 8'h43);
        rd(3, v); chk("pop_empty", v, 8'h00);
        rd(2, v); chk("stat_empty", v, 8'h00);
        for (int i = 0; i <= CAP; i++) key(8'hA0 + 8'(i));
        rd(2, v); chk("stat_full", v, 8'h83);
        for (int i = 0; i < CAP; i++) begin
            rd(3, v); chk("pop_ovf", v, 8'hA0 + 8'(i));
        end
        wr(2, 8'h02);
        rd(2, v); chk("ovf_clr", v, 8'h00);
        for (int i = 0; i < CAP; i++) key(8'hB0 + 8'(i));
        step(adr(3), 8'h00, 1'b1, 1'b0, 1'b1, 8'hEE, v);
        chk("full_pp_head", v, 8'hB0);
        rd(2, v); chk("full_pp_stat", v, 8'h81);
        for (int i = 1; i < CAP; i++) rd(3, v);
        rd(3, v); chk("full_pp_last", v, 8'hEE);
`else
        key(8'h10);
        #1 chk("irq_key", irq, 1'b1);
        key(8'h20);
        rd(2, v); chk("latch_stat", v, 8'h13);
        rd(3, v); chk("latch_pop", v, 8'h20);
        wr(2, 8'h02);
        key(8'h30);
        step(adr(3), 8'h00, 1'b1, 1'b0, 1'b1, 8'h40, v);
        chk("latch_pp_head", v, 8'h30);
        rd(2, v); chk("latch_pp_stat", v, 8'h11);
        rd(3, v); chk("latch_pp_new", v, 8'h40);
`endif
        step(adr(3), 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, v);
        chk("empty_pp_ret", v, 8'h00);
        rd(2, v); chk("empty_pp_stat", v, 8'h11);
        rd(3, v);
        wr(3, 8'h00);

        // Timer: tick at 10, clear wins over tick, W1C loses to tick, wrap after 2560
        wr(4, 8'h03);
        wr(2, 8'h04);
        idle(8);
        rd(2, v); chk("pend_before", v[2], 1'b0);
        rd(2, v); chk("pend_at10", v[2], 1'b1);
        wr(3, 8'h02);
        #1 chk("irq_tick", irq, 1'b1);
        idle(2538);
        rd(1, v); chk("tcnt_255", v, 8'd255);
        idle(9);
        rd(1, v); chk("tcnt_wrap", v, 8'd0);
        wait_pre_tick();
        wr(2, 8'h04);
        rd(2, v); chk("w1c_on_tick", v[2], 1'b1);
        idle(3);
        wait_pre_tick();
        wr(4, 8'h03);
        rd(1, v); chk("clr_beats_tick", v, 8'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            aa = (sel == 0) ? 16'($urandom) : adr($urandom_range(0, 7));
            if (aa == adr(4) && $urandom_range(0, 3) != 0) aa = adr(2);
            step(aa, 8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), 8'($urandom), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
